// File: rtl/addsub_pkg.sv
// Shared types for the digit-serial add/subtract/negate unit.
//   op_e    : operation select encoding presented on the op port
//   state_e : sequencing states of the serial engine
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_INC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_serial_digit_adder.sv
// digit_adder: combinational W-bit ripple-carry adder used for one digit per cycle.
//   x, y  : W-bit digit operands
//   cin   : carry into bit 0
//   s     : W-bit digit sum
//   cout  : carry out of bit W-1
//   c_msb : carry into bit W-1 (feeds signed overflow on the most significant digit)
module digit_adder #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]     = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
  end

  assign cout  = c_s[W];
  assign c_msb = c_s[W-1];

endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement ADD / SUB / NEG / INC unit.
// An N-bit operation is processed W bits per cycle, least significant digit
// first, through one carry register; D = N/W cycles per operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted on a rising edge while ready is high
//   op         : 00 ADD a+b, 01 SUB a-b, 10 NEG -a, 11 INC a+1
//   a, b       : operands, sampled only at acceptance
//   ready      : high in IDLE and DONE
//   done       : one-cycle pulse when result/flags are newly valid
//   result     : N-bit result, held until the next completion
//   cout       : carry out of bit N-1 (SUB: 1 = no borrow)
//   ovf        : signed overflow
//   zero, neg  : result == 0, result[N-1]
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int D  = N / W;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

  if ((N < 1) || (W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_param
    $error("addsub_serial: W must satisfy 1 <= W <= N and divide N");
  end

  state_e        state_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  x_r;
  logic [N-1:0]  y_r;
  logic          carry_r;
  logic [N-1:0]  acc_r;
  logic [N-1:0]  result_r;
  logic          cout_r;
  logic          ovf_r;
  logic          zero_r;
  logic          neg_r;
  logic          done_r;
  logic          ready_r;

  logic [N-1:0]  x_load_s;
  logic [N-1:0]  y_load_s;
  logic          c_load_s;
  logic [W-1:0]  dsum_s;
  logic          dcout_s;
  logic          dmsb_s;
  logic [N-1:0]  acc_next_s;

  // Map the requested operation onto X + Y + carry-in.
  always_comb begin
    x_load_s = a;
    y_load_s = b;
    c_load_s = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        x_load_s = a;
        y_load_s = b;
        c_load_s = 1'b0;
      end
      OP_SUB: begin
        x_load_s = a;
        y_load_s = ~b;
        c_load_s = 1'b1;
      end
      OP_NEG: begin
        x_load_s = {N{1'b0}};
        y_load_s = ~a;
        c_load_s = 1'b1;
      end
      OP_INC: begin
        x_load_s = a;
        y_load_s = {N{1'b0}};
        c_load_s = 1'b1;
      end
      default: begin
        x_load_s = a;
        y_load_s = b;
        c_load_s = 1'b0;
      end
    endcase
  end

  digit_adder #(.W(W)) u_digit (
    .x     (x_r[W-1:0]),
    .y     (y_r[W-1:0]),
    .cin   (carry_r),
    .s     (dsum_s),
    .cout  (dcout_s),
    .c_msb (dmsb_s)
  );

  // New digits enter at the MSB side so the final digit lands the word in place.
  if (D == 1) begin : g_acc_single
    assign acc_next_s = dsum_s;
  end else begin : g_acc_multi
    assign acc_next_s = {dsum_s, acc_r[N-1:W]};
  end

  // Sequencer, operand/result shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      x_r      <= {N{1'b0}};
      y_r      <= {N{1'b0}};
      carry_r  <= 1'b0;
      acc_r    <= {N{1'b0}};
      result_r <= {N{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
      neg_r    <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            x_r     <= x_load_s;
            y_r     <= y_load_s;
            carry_r <= c_load_s;
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
            ready_r <= 1'b0;
          end else begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end
        end
        RUN: begin
          x_r     <= x_r >> W;
          y_r     <= y_r >> W;
          carry_r <= dcout_s;
          acc_r   <= acc_next_s;
          cnt_r   <= cnt_r + CW'(1'b1);
          if (cnt_r == LAST_DIGIT) begin
            // Final digit: its carries are those of bit N-1.
            result_r <= acc_next_s;
            cout_r   <= dcout_s;
            ovf_r    <= dmsb_s ^ dcout_s;
            zero_r   <= (acc_next_s == {N{1'b0}});
            neg_r    <= acc_next_s[N-1];
            done_r   <= 1'b1;
            ready_r  <= 1'b1;
            state_r  <= DONE;
          end else begin
            state_r <= RUN;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;
  assign zero   = zero_r;
  assign neg    = neg_r;

endmodule
